// File: rtl/pci_target.sv
// pci_target: memory-mapped PCI target with a four-word register file.
// Claims memory read/write cycles in a 16-byte window at BASE_ADDR. Handles
// single and burst data phases, initiator wait states and initiator abort.
//   clk       bus clock, all sampling on the rising edge
//   reset_n   asynchronous active-low reset
//   ad        multiplexed address/data; driven only while serving read data
//   c_be      command in the address phase, active-low byte enables in data
//   frame_n   active-low frame; high in a data phase marks the last phase
//   irdy_n    active-low initiator ready
//   devsel_n  active-low device select (tri-state)
//   trdy_n    active-low target ready (tri-state)
module pci_target #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0010
) (
  input  logic        clk,
  input  logic        reset_n,
  inout  logic [31:0] ad,
  input  logic [3:0]  c_be,
  input  logic        frame_n,
  input  logic        irdy_n,
  output logic        devsel_n,
  output logic        trdy_n
);

  localparam logic [3:0] CMD_MEM_RD = 4'b0110;
  localparam logic [3:0] CMD_MEM_WR = 4'b0111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_DATA,
    S_RD_TURN,
    S_RD_DATA,
    S_BACKOFF,
    S_IGNORE
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] mem_q [4];
  logic [31:0] mem_d [4];

  logic hit;
  assign hit = (ad[31:4] == BASE_ADDR[31:4]);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mem_d   = mem_q;
    unique case (state_q)
      S_IDLE: begin
        if (!frame_n) begin
          idx_d = ad[3:2];
          if (hit && c_be == CMD_MEM_WR)      state_d = S_WR_DATA;
          else if (hit && c_be == CMD_MEM_RD) state_d = S_RD_TURN;
          else                                state_d = S_IGNORE;
        end
      end
      S_WR_DATA, S_RD_DATA: begin
        if (!irdy_n) begin
          // trdy_n is always asserted here, so irdy_n alone completes a phase
          if (state_q == S_WR_DATA) begin
            for (int unsigned i = 0; i < 4; i++) begin
              if (!c_be[i]) mem_d[idx_q][8*i +: 8] = ad[8*i +: 8];
            end
          end
          idx_d = idx_q + 2'd1;
          if (frame_n) state_d = S_BACKOFF;
        end else if (frame_n) begin
          state_d = S_BACKOFF;
        end
      end
      S_RD_TURN: state_d = S_RD_DATA;
      S_BACKOFF: state_d = S_IDLE;
      S_IGNORE: begin
        if (frame_n && irdy_n) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      for (int unsigned i = 0; i < 4; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mem_q   <= mem_d;
    end
  end

  // BACKOFF drives devsel_n/trdy_n high for one cycle before releasing them.
  assign devsel_n = (state_q == S_WR_DATA || state_q == S_RD_TURN ||
                     state_q == S_RD_DATA) ? 1'b0 :
                    (state_q == S_BACKOFF) ? 1'b1 : 1'bz;
  assign trdy_n   = (state_q == S_WR_DATA || state_q == S_RD_DATA) ? 1'b0 :
                    (state_q == S_RD_TURN || state_q == S_BACKOFF) ? 1'b1 : 1'bz;
  assign ad       = (state_q == S_RD_DATA) ? mem_q[idx_q] : 'z;

endmodule

// File: tb/tb_pci_target.sv
// Self-checking bench for pci_target. Shared lines are pulled up, so a
// released line reads back as all ones.
module tb_pci_target;

  localparam logic [31:0] BASE = 32'h0000_0010;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] ad_drv;
  logic        ad_oe;
  logic [3:0]  c_be;
  logic        frame_n;
  logic        irdy_n;
  tri1  [31:0] ad;
  tri1         devsel_n;
  tri1         trdy_n;

  assign ad = ad_oe ? ad_drv : 'z;

  pci_target #(.BASE_ADDR(BASE)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .ad       (ad),
    .c_be     (c_be),
    .frame_n  (frame_n),
    .irdy_n   (irdy_n),
    .devsel_n (devsel_n),
    .trdy_n   (trdy_n)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] mem_m [4];
  logic [31:0] wd [4];
  logic [3:0]  wb [4];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One complete bus cycle: address phase, n data phases with wmin..wmax
  // initiator wait cycles before each, then one idle cycle. Write data comes
  // from wd/wb. Expectations come from the word-level model mem_m.
  task automatic bus_xfer(input logic [31:0] addr, input logic [3:0] cmd, input int n,
                          input int unsigned wmin, input int unsigned wmax);
    bit          is_hit, is_wr, is_rd, rd_cmd;
    int unsigned w, waits;
    is_hit = (addr[31:4] == BASE[31:4]);
    is_wr  = is_hit && (cmd == 4'b0111);
    is_rd  = is_hit && (cmd == 4'b0110);
    rd_cmd = (cmd == 4'b0110);

    @(negedge clk);
    frame_n = 1'b0; irdy_n = 1'b1; ad_oe = 1'b1; ad_drv = addr; c_be = cmd;
    @(negedge clk);
    chk("devsel_after_addr", devsel_n, (is_wr || is_rd) ? 32'd0 : 32'd1);
    chk("trdy_after_addr", trdy_n, is_wr ? 32'd0 : 32'd1);
    if (rd_cmd) begin
      ad_oe = 1'b0; c_be = 4'b0000; frame_n = 1'b0; irdy_n = 1'b1;
      @(negedge clk);
      chk("trdy_after_turn", trdy_n, is_rd ? 32'd0 : 32'd1);
    end
    for (int k = 0; k < n; k++) begin
      w = (int'(addr[3:2]) + k) % 4;
      waits = $urandom_range(wmax, wmin);
      if (rd_cmd) begin
        ad_oe = 1'b0; c_be = 4'b0000;
      end else begin
        ad_oe = 1'b1; ad_drv = wd[k]; c_be = wb[k];
      end
      for (int unsigned q = 0; q < waits; q++) begin
        frame_n = 1'b0; irdy_n = 1'b1;
        if (rd_cmd) chk("rd_wait_ad", ad, is_rd ? mem_m[w] : 32'hFFFF_FFFF);
        chk("wait_devsel", devsel_n, (is_wr || is_rd) ? 32'd0 : 32'd1);
        @(negedge clk);
      end
      irdy_n = 1'b0; frame_n = (k == n - 1);
      if (rd_cmd) chk("rd_data_ad", ad, is_rd ? mem_m[w] : 32'hFFFF_FFFF);
      chk("data_trdy", trdy_n, (is_wr || is_rd) ? 32'd0 : 32'd1);
      @(negedge clk);
      if (is_wr)
        for (int b = 0; b < 4; b++)
          if (!wb[k][b]) mem_m[w][8*b +: 8] = wd[k][8*b +: 8];
    end
    ad_oe = 1'b0; frame_n = 1'b1; irdy_n = 1'b1; c_be = 4'b0000;
    #1;
    chk("end_devsel", devsel_n, 32'd1);
    chk("end_trdy", trdy_n, 32'd1);
    chk("end_ad_released", ad, 32'hFFFF_FFFF);
  endtask

  task automatic read_all();
    for (int i = 0; i < 4; i++) bus_xfer(BASE + 32'(4 * i), 4'b0110, 1, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] addr;
    logic [3:0]  cmd;
    int          r, n;

    reset_n = 1'b0; ad_oe = 1'b0; ad_drv = '0; c_be = '0; frame_n = 1'b1; irdy_n = 1'b1;
    for (int i = 0; i < 4; i++) mem_m[i] = '0;
    #1;
    chk("reset_devsel", devsel_n, 32'd1);
    chk("reset_trdy", trdy_n, 32'd1);
    chk("reset_ad", ad, 32'hFFFF_FFFF);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    read_all();

    // single write then single read
    wd[0] = 32'hAAAA_AAAA; wb[0] = 4'b0000;
    bus_xfer(32'h0000_0014, 4'b0111, 1, 0, 0);
    bus_xfer(32'h0000_0014, 4'b0110, 1, 0, 0);

    // byte enables
    wd[0] = 32'hBBBB_DFBB; wb[0] = 4'b0000;
    bus_xfer(32'h0000_0010, 4'b0111, 1, 0, 0);
    wd[0] = 32'h1111_1111; wb[0] = 4'b1010;
    bus_xfer(32'h0000_0010, 4'b0111, 1, 0, 0);
    bus_xfer(32'h0000_0010, 4'b0110, 1, 0, 0);

    // wrapping burst
    for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); wb[i] = 4'b0000; end
    bus_xfer(32'h0000_001C, 4'b0111, 4, 0, 0);
    read_all();
    bus_xfer(32'h0000_001C, 4'b0110, 4, 0, 0);

    // miss and ignored command
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hDEAD_0000 | 32'(i); wb[i] = 4'b0000; end
    bus_xfer(32'h0000_0020, 4'b0111, 2, 0, 0);
    bus_xfer(32'h0000_0010, 4'b0010, 2, 0, 0);
    bus_xfer(32'h0000_0030, 4'b0110, 2, 0, 0);
    read_all();

    // wait states on a read burst
    bus_xfer(32'h0000_0018, 4'b0110, 4, 2, 2);

    // randomized traffic
    for (int t = 0; t < 40; t++) begin
      r = $urandom_range(9, 0);
      n = $urandom_range(4, 1);
      for (int i = 0; i < 4; i++) begin
        wd[i] = $urandom;
        wb[i] = 4'($urandom_range(15, 0));
      end
      addr = BASE | (32'($urandom_range(3, 0)) << 2);
      cmd  = (r < 5) ? 4'b0111 : 4'b0110;
      if (r == 8) addr = {4'($urandom_range(15, 1)), addr[27:0]};
      if (r == 9) cmd = 4'b0011;
      bus_xfer(addr, cmd, n, 0, 2);
    end
    read_all();

    // reset in the second phase of a write burst
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hC0DE_0000 | 32'(i); wb[i] = 4'b0000; end
    @(negedge clk);
    frame_n = 1'b0; irdy_n = 1'b1; ad_oe = 1'b1; ad_drv = BASE; c_be = 4'b0111;
    @(negedge clk);
    ad_drv = wd[0]; c_be = 4'b0000; irdy_n = 1'b0;
    @(negedge clk);
    ad_drv = wd[1];
    chk("burst_devsel_before_reset", devsel_n, 32'd0);
    #2;
    ad_oe = 1'b0; frame_n = 1'b1; irdy_n = 1'b1;
    reset_n = 1'b0;
    for (int i = 0; i < 4; i++) mem_m[i] = '0;
    #1;
    chk("midreset_devsel", devsel_n, 32'd1);
    chk("midreset_trdy", trdy_n, 32'd1);
    chk("midreset_ad", ad, 32'hFFFF_FFFF);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    read_all();
    bus_xfer(BASE, 4'b0110, 4, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
